// File: rtl/mask_centroid.sv
// mask_centroid: accumulates the coordinates of set pixels in a binary mask
// stream and, at each frame end, divides the coordinate sums by the pixel count
// with two serial restoring dividers to give the object centroid.
module mask_centroid #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int MIN_PIXELS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mask_bit,
   input  logic        mask_valid,
   input  logic        frame_done_in,
   output logic [9:0]  centroid_x,
   output logic [8:0]  centroid_y,
   output logic [18:0] pixel_count,
   output logic        object_found,
   output logic        result_valid,
   output logic        busy,
   output logic        frame_dropped
);

   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_DIV     = 2'd1;
   localparam logic [1:0]  S_DONE    = 2'd2;
   localparam logic [9:0]  X_LAST    = 10'(IMG_W - 1);
   localparam logic [8:0]  Y_LAST    = 9'(IMG_H - 1);
   localparam logic [18:0] MIN_CNT   = 19'(MIN_PIXELS);
   localparam logic [4:0]  LAST_ITER = 5'd26;

   // One restoring-division step: shift the next dividend bit into the
   // partial remainder and subtract the divisor when it fits.
   // Returns {new remainder, quotient bit}. The remainder is always below the
   // divisor, so after a successful subtract it fits in 19 bits again.
   function automatic logic [19:0] div_step(input logic [18:0] rem,
                                            input logic        msb,
                                            input logic [18:0] den);
      logic [19:0] trial;
      trial = {rem, msb};
      if (trial >= {1'b0, den})
         div_step = {trial[18:0] - den, 1'b1};
      else
         div_step = {trial[18:0], 1'b0};
   endfunction

   logic [9:0]  x;
   logic [8:0]  y;
   logic [26:0] sum_x, sum_y;
   logic [18:0] cnt;
   logic        pix;
   logic [26:0] sum_x_nxt, sum_y_nxt;
   logic [18:0] cnt_nxt;

   logic [1:0]  state;
   logic [4:0]  iter;
   logic [26:0] num_x, num_y;
   logic [18:0] rem_x, rem_y;
   logic [18:0] den;
   logic [9:0]  q_x;
   logic [8:0]  q_y;
   logic [19:0] step_x, step_y;

   // Accumulator values including the pixel qualified this cycle, so a pixel
   // coincident with frame_done_in lands in the snapshot of the ending frame.
   always_comb begin
      pix       = mask_valid & mask_bit;
      sum_x_nxt = sum_x + (pix ? {17'd0, x} : 27'd0);
      sum_y_nxt = sum_y + (pix ? {18'd0, y} : 27'd0);
      cnt_nxt   = cnt + {18'd0, pix};
      step_x    = div_step(rem_x, num_x[26], den);
      step_y    = div_step(rem_y, num_y[26], den);
   end

   assign busy = (state == S_DIV);

   // Raster coordinate counters and set-pixel accumulators; every frame end
   // restarts them regardless of divider state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x     <= '0;
         y     <= '0;
         sum_x <= '0;
         sum_y <= '0;
         cnt   <= '0;
      end else if (frame_done_in) begin
         x     <= '0;
         y     <= '0;
         sum_x <= '0;
         sum_y <= '0;
         cnt   <= '0;
      end else begin
         if (mask_valid) begin
            if (x == X_LAST) begin
               x <= '0;
               if (y != Y_LAST)
                  y <= y + 9'd1;
            end else begin
               x <= x + 10'd1;
            end
         end
         sum_x <= sum_x_nxt;
         sum_y <= sum_y_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Frame-end sequencing: snapshot, 27-step division, result publication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         iter          <= '0;
         num_x         <= '0;
         num_y         <= '0;
         rem_x         <= '0;
         rem_y         <= '0;
         den           <= '0;
         q_x           <= '0;
         q_y           <= '0;
         centroid_x    <= '0;
         centroid_y    <= '0;
         pixel_count   <= '0;
         object_found  <= 1'b0;
         result_valid  <= 1'b0;
         frame_dropped <= 1'b0;
      end else begin
         result_valid  <= 1'b0;
         frame_dropped <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_done_in) begin
                  num_x <= sum_x_nxt;
                  num_y <= sum_y_nxt;
                  den   <= cnt_nxt;
                  rem_x <= '0;
                  rem_y <= '0;
                  q_x   <= '0;
                  q_y   <= '0;
                  iter  <= '0;
                  state <= (cnt_nxt >= MIN_CNT) ? S_DIV : S_DONE;
               end
            end
            S_DIV: begin
               rem_x <= step_x[19:1];
               rem_y <= step_y[19:1];
               q_x   <= {q_x[8:0], step_x[0]};
               q_y   <= {q_y[7:0], step_y[0]};
               num_x <= {num_x[25:0], 1'b0};
               num_y <= {num_y[25:0], 1'b0};
               iter  <= iter + 5'd1;
               if (iter == LAST_ITER)
                  state <= S_DONE;
               if (frame_done_in)
                  frame_dropped <= 1'b1;
            end
            S_DONE: begin
               // den still holds the snapshot count, which tells whether a
               // division ran for this frame.
               if (den >= MIN_CNT) begin
                  centroid_x   <= q_x;
                  centroid_y   <= q_y;
                  object_found <= 1'b1;
               end else begin
                  object_found <= 1'b0;
               end
               pixel_count  <= den;
               result_valid <= 1'b1;
               state        <= S_IDLE;
               if (frame_done_in)
                  frame_dropped <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mask_centroid.sv
// Scoreboard bench for mask_centroid on a reduced 128x96 image so every frame
// fits in a short run.
module tb_mask_centroid;

   localparam int W   = 128;
   localparam int H   = 96;
   localparam int NSQ = 57 * W + 108;   // stream up to and including (107, 57)

   logic        clk = 1'b0;
   logic        rst;
   logic        mask_bit;
   logic        mask_valid;
   logic        frame_done_in;
   logic [9:0]  centroid_x;
   logic [8:0]  centroid_y;
   logic [18:0] pixel_count;
   logic        object_found;
   logic        result_valid;
   logic        busy;
   logic        frame_dropped;

   mask_centroid #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .mask_bit      (mask_bit),
      .mask_valid    (mask_valid),
      .frame_done_in (frame_done_in),
      .centroid_x    (centroid_x),
      .centroid_y    (centroid_y),
      .pixel_count   (pixel_count),
      .object_found  (object_found),
      .result_valid  (result_valid),
      .busy          (busy),
      .frame_dropped (frame_dropped)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   // Edge counter: after edge N, cyc reads N.
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cx;
      int cy;
      int cnt;
      int found;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total  = 0;
   int   passed = 0;
   int   drops  = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp)
         passed++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic is_set(input int kind, input int px, input int py);
      case (kind)
         0:       return (px >= 100 && px <= 107 && py >= 50 && py <= 57);
         1:       return (py == 0 && px < 10);
         2:       return 1'b1;
         default: return (px == W - 1 && py == H - 1);
      endcase
   endfunction

   // Streams n raster pixels, then ends the frame (on the last pixel when
   // coincide is set). t_edge is the edge that sampled frame_done_in.
   task automatic send_frame(input int kind, input int n, input logic coincide,
                             output int t_edge);
      for (int i = 0; i < n; i++) begin
         mask_valid    = 1'b1;
         mask_bit      = is_set(kind, i % W, i / W);
         frame_done_in = coincide && (i == n - 1);
         @(posedge clk); #1;
      end
      if (!coincide) begin
         mask_valid    = 1'b0;
         mask_bit      = 1'b0;
         frame_done_in = 1'b1;
         @(posedge clk); #1;
      end
      t_edge        = cyc;
      frame_done_in = 1'b0;
      mask_valid    = 1'b0;
      mask_bit      = 1'b0;
   endtask

   task automatic push(input int cx, input int cy, input int cnt, input int found,
                       input int at);
      exp_t e;
      e.cx = cx; e.cy = cy; e.cnt = cnt; e.found = found; e.cyc = at;
      sb.push_back(e);
   endtask

   task automatic watch_busy(input int exp_cycles);
      int b = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy) b++;
      end
      chk("busy_cycles", b, exp_cycles);
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk("sb_drain", sb.size(), 0);
   endtask

   // Monitor: every result_valid strobe is matched against the scoreboard.
   always @(negedge clk) begin
      if (frame_dropped) drops <= drops + 1;
      if (result_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("centroid_x",   int'(centroid_x),   mon_e.cx);
            chk("centroid_y",   int'(centroid_y),   mon_e.cy);
            chk("pixel_count",  int'(pixel_count),  mon_e.cnt);
            chk("object_found", int'(object_found), mon_e.found);
            chk("result_cycle", cyc,                mon_e.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      rst           = 1'b1;
      mask_bit      = 1'b0;
      mask_valid    = 1'b0;
      frame_done_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_centroid_x",    int'(centroid_x),    0);
      chk("rst_centroid_y",    int'(centroid_y),    0);
      chk("rst_pixel_count",   int'(pixel_count),   0);
      chk("rst_object_found",  int'(object_found),  0);
      chk("rst_result_valid",  int'(result_valid),  0);
      chk("rst_busy",          int'(busy),          0);
      chk("rst_frame_dropped", int'(frame_dropped), 0);

      // 8x8 square at (100, 50)
      send_frame(0, NSQ, 1'b0, t);
      push(103, 53, 64, 1, t + 28);
      watch_busy(27);
      drain();

      // 10 pixels: below threshold, centroid held
      send_frame(1, 20, 1'b0, t);
      push(103, 53, 10, 0, t + 1);
      watch_busy(0);
      drain();

      // full all-ones frame, last pixel coincident with frame end
      send_frame(2, W * H, 1'b1, t);
      push(63, 47, W * H, 1, t + 28);
      watch_busy(27);
      drain();

      // only the last pixel set, coincident with frame end
      send_frame(3, W * H, 1'b1, t);
      push(63, 47, 1, 0, t + 1);
      watch_busy(0);
      drain();

      // second frame end 10 cycles after the first: dropped, pixels discarded
      send_frame(0, NSQ, 1'b0, t);
      push(103, 53, 64, 1, t + 28);
      repeat (9) begin
         mask_valid = 1'b1;
         mask_bit   = 1'b1;
         @(posedge clk); #1;
      end
      mask_valid    = 1'b0;
      mask_bit      = 1'b0;
      frame_done_in = 1'b1;
      @(posedge clk); #1;
      frame_done_in = 1'b0;
      chk("frame_dropped", int'(frame_dropped), 1);
      chk("busy_at_drop",  int'(busy),          1);
      send_frame(0, NSQ, 1'b0, t);
      push(103, 53, 64, 1, t + 28);
      watch_busy(27);
      drain();

      // reset in the middle of a division: no result, outputs cleared
      send_frame(0, NSQ, 1'b0, t);
      repeat (12) @(posedge clk);
      #1;
      chk("busy_before_rst", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("midrst_centroid_x",   int'(centroid_x),   0);
      chk("midrst_centroid_y",   int'(centroid_y),   0);
      chk("midrst_pixel_count",  int'(pixel_count),  0);
      chk("midrst_object_found", int'(object_found), 0);
      chk("midrst_busy",         int'(busy),         0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (40) @(negedge clk);
      send_frame(0, NSQ, 1'b0, t);
      push(103, 53, 64, 1, t + 28);
      watch_busy(27);
      drain();

      chk("drop_count", drops, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
